// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer:
// adder slice width and FSM state encodings.
package nibble_serial_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_full_adder_4bit.sv
// Purely combinational 4-bit adder slice with carry in/out,
// reused once per nibble by the sequencer.
module full_adder_4bit
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] w_full;

  // One add produces both the nibble sum and its carry out
  always_comb begin
    w_full = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
    sum    = w_full[NIBBLE_W-1:0];
    cout   = w_full[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds two WIDTH-bit operands one nibble per cycle through a
// single 4-bit adder, carrying between cycles in a register.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = $clog2(NIB);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic [NIBBLE_W-1:0] w_fa_a;
  logic [NIBBLE_W-1:0] w_fa_b;
  logic [NIBBLE_W-1:0] w_fa_sum;
  logic               w_fa_cout;
  logic               w_last;

  // Route the current nibble of each operand into the adder
  always_comb begin
    w_fa_a = '0;
    w_fa_b = '0;
    for (int k = 0; k < NIB; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_fa_a = r_op_a[k*NIBBLE_W +: NIBBLE_W];
        w_fa_b = r_op_b[k*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  full_adder_4bit u_fa (
    .a    (w_fa_a),
    .b    (w_fa_b),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  assign w_last = (r_idx == LAST);

  // Next-state decode; the unused encoding falls back to idle
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_next = ST_RUN;
      ST_RUN:  if (w_last)    w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  // State, operand capture, nibble writeback and carry ripple
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && in_valid) begin
        r_op_a  <= a;
        r_op_b  <= b;
        r_carry <= cin;
        r_idx   <= '0;
        r_sum   <= '0;
      end else if (r_state == ST_RUN) begin
        for (int k = 0; k < NIB; k++) begin
          if (r_idx == IDX_W'(k)) begin
            r_sum[k*NIBBLE_W +: NIBBLE_W] <= w_fa_sum;
          end
        end
        r_carry <= w_fa_cout;
        if (w_last) begin
          r_idx  <= '0;
          r_cout <= w_fa_cout;
        end else begin
          r_idx  <= r_idx + 1'b1;
        end
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule
